serial_word_feeder: RTL
=======================

// Module: serial_word_feeder
// PURPOSE
//   Upstream stage of the single-bit sequence-detector FSM. Accepts parallel words on a
//   valid/ready handshake and shifts them out one bit per clock on serial_out, which drives
//   the FSM's In port. A one-word holding register lets the next word arrive while the
//   current one shifts, so frames run back-to-back. Optional idle gap between frames.
// PARAMETERS
//   WIDTH      8  bits per word (>=2)
//   MSB_FIRST  1  1: data_in[WIDTH-1] goes out first; 0: data_in[0] goes out first
//   GAP        0  idle cycles inserted between consecutive frames (0..15)
//   IDLE_LEVEL 0  serial_out value whenever no bit is being driven
// PORTS
//   clock        in   1      single clock, all state changes on posedge
//   reset_b      in   1      synchronous, active-low reset
//   data_in      in   WIDTH  parallel word
//   valid_in     in   1      data_in valid
//   ready_out    out  1      holding register empty; transfer when valid_in & ready_out
//   hold         in   1      stall: freeze shifting/gap counting
//   serial_out   out  1      serial bit stream (to FSM In)
//   bit_valid    out  1      serial_out carries a live data bit this cycle
//   frame_start  out  1      first bit of a frame on serial_out
//   frame_last   out  1      last bit of a frame on serial_out
//   busy         out  1      state!=IDLE or holding register full
// BEHAVIOUR
//   Reset (reset_b=0 at posedge): state IDLE, holding reg empty, bit count 0, gap count 0.
//     Following cycle: ready_out=1, serial_out=IDLE_LEVEL, bit_valid=frame_start=frame_last=busy=0.
//     Reset mid-frame aborts; current and held words are discarded, no partial resume.
//   States: IDLE, SHIFT, GAP. All outputs registered or decoded from registered state only.
//   Accept: valid_in & ready_out at posedge -> word captured into holding reg; ready_out=0 next.
//   Load: holding reg full and (state IDLE, or SHIFT last bit with GAP=0, or GAP last cycle)
//     and hold=0 -> word moves to shift reg, holding reg empties, state SHIFT, bit count 0.
//   Latency: word accepted at edge k appears as first bit during cycle after edge k+1 (idle case).
//   SHIFT: one bit per non-held cycle, order per MSB_FIRST; bit_valid=1; frame_start=1 at
//     count 0; frame_last=1 at count WIDTH-1. After last bit: GAP>0 -> GAP; else load next
//     word if held (zero-bubble back-to-back), otherwise IDLE.
//   GAP: serial_out=IDLE_LEVEL, bit_valid=0 for exactly GAP non-held cycles, then load or IDLE.
//   hold=1: SHIFT/GAP counters and shift reg freeze, serial_out keeps its value, bit_valid,
//     frame_start, frame_last forced 0; no load occurs. Accept into holding reg still allowed.
//   ready_out = ~holding_full; a word cannot be accepted on the edge the holding reg unloads
//     (ready_out was 0); earliest next accept is the following edge.
//   valid_in with ready_out=0: ignored, no state change; source must keep data stable.
//   Bit counter $clog2(WIDTH) bits, never exceeds WIDTH-1; gap counter 4 bits, no wrap.
// TESTING
//   WIDTH=8,MSB_FIRST=1,GAP=0: send 8'hA5 -> serial_out 1,0,1,0,0,1,0,1, frame_start cycle 1,
//     frame_last cycle 8, then IDLE_LEVEL, busy=0.
//   Back-to-back 8'hF0 then 8'h0F, second offered during first -> 16 contiguous bit_valid
//     cycles, no bubble, second frame_start directly after first frame_last.
//   GAP=3, two words -> exactly 3 cycles of bit_valid=0 between frame_last and next frame_start.
//   MSB_FIRST=0, send 8'h01 -> first bit 1 then seven 0s.
//   hold asserted 2 cycles at bit 4 of 8'hC3 -> serial_out frozen, bit_valid=0 both cycles,
//     remaining bits resume unchanged; total frame spans 10 cycles.
//   reset_b=0 at bit 5 with word held -> next cycle serial_out=IDLE_LEVEL, ready_out=1,
//     busy=0; next accepted word 8'h81 shifts cleanly from its bit 0.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the sequence-detector FSM: a one-word holding register in front
// of a shift register, so frames can run back-to-back, with an optional idle gap between frames.
module serial_word_feeder #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             hold,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned      GAP_W    = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hold_data;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_serial;
    logic             r_bit_valid;
    logic             r_frame_start;
    logic             r_frame_last;

    logic [1:0]       w_state;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_full;
    logic [WIDTH-1:0] w_shift;
    logic [CNT_W-1:0] w_bit_cnt;
    logic [GAP_W-1:0] w_gap_cnt;
    logic             w_serial;
    logic             w_bit_valid;
    logic             w_frame_start;
    logic             w_frame_last;
    logic             w_load;

    // The shift register holds only the bits not yet shown; serial_out holds the current bit.
    logic             w_first_bit;
    logic [WIDTH-1:0] w_hold_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_adv;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_first_bit = MSB_FIRST ? r_hold_data[WIDTH-1] : r_hold_data[0];
    assign w_hold_rest = MSB_FIRST ? (r_hold_data << 1) : (r_hold_data >> 1);
    assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shift_adv = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    assign w_cnt_inc   = r_bit_cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            r_state       <= S_IDLE;
            r_hold_data   <= '0;
            r_hold_full   <= 1'b0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_serial      <= IDLE_LEVEL;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_last  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_hold_data   <= w_hold_data;
            r_hold_full   <= w_hold_full;
            r_shift       <= w_shift;
            r_bit_cnt     <= w_bit_cnt;
            r_gap_cnt     <= w_gap_cnt;
            r_serial      <= w_serial;
            r_bit_valid   <= w_bit_valid;
            r_frame_start <= w_frame_start;
            r_frame_last  <= w_frame_last;
        end
    end

    // Held edges keep everything frozen except the holding register, and drop the bit strobes.
    always_comb begin
        w_state       = r_state;
        w_hold_data   = r_hold_data;
        w_hold_full   = r_hold_full;
        w_shift       = r_shift;
        w_bit_cnt     = r_bit_cnt;
        w_gap_cnt     = r_gap_cnt;
        w_serial      = r_serial;
        w_bit_valid   = 1'b0;
        w_frame_start = 1'b0;
        w_frame_last  = 1'b0;
        w_load        = 1'b0;

        if (!hold) begin
            case (r_state)
                S_IDLE: begin
                    w_load = r_hold_full;
                end
                S_SHIFT: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (GAP > 0) begin
                            w_state   = S_GAP;
                            w_gap_cnt = '0;
                            w_serial  = IDLE_LEVEL;
                        end else if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state  = S_IDLE;
                            w_serial = IDLE_LEVEL;
                        end
                    end else begin
                        w_bit_cnt    = w_cnt_inc;
                        w_serial     = w_next_bit;
                        w_shift      = w_shift_adv;
                        w_bit_valid  = 1'b1;
                        w_frame_last = (w_cnt_inc == LAST_BIT);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state  = S_IDLE;
                            w_serial = IDLE_LEVEL;
                        end
                    end else begin
                        w_gap_cnt = r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    w_state  = S_IDLE;
                    w_serial = IDLE_LEVEL;
                end
            endcase
        end

        // A load presents the first bit immediately; no accept can coincide since ready_out is low.
        if (w_load) begin
            w_state       = S_SHIFT;
            w_bit_cnt     = '0;
            w_serial      = w_first_bit;
            w_shift       = w_hold_rest;
            w_hold_full   = 1'b0;
            w_bit_valid   = 1'b1;
            w_frame_start = 1'b1;
        end else if (valid_in && !r_hold_full) begin
            w_hold_data = data_in;
            w_hold_full = 1'b1;
        end
    end

    assign ready_out   = ~r_hold_full;
    assign serial_out  = r_serial;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;
    assign frame_last  = r_frame_last;
    assign busy        = (r_state != S_IDLE) | r_hold_full;

endmodule
